// File: rtl/sarray_spad_master_pkg.sv
// Shared constants for the sarray spad master: state/op encodings and width defaults.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 256
`endif

`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 256
`endif

package sarray_spad_master_pkg;

  localparam int SSM_ADDR_WIDTH  = `ADDR_WIDTH;
  localparam int SSM_LOAD_WIDTH  = `SARRAY_LOAD_WIDTH;
  localparam int SSM_STORE_WIDTH = `SARRAY_STORE_WIDTH;

  localparam int SSM_LEN_WIDTH  = 16;
  localparam int SSM_FIFO_DEPTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/sarray_ld_fifo.sv
// Load-data FIFO; count_o feeds the ar credit check in the master.
module sarray_ld_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == (PW+1)'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  // when full, a simultaneous pop frees the head slot being overwritten
  assign do_push    = push_i & (~full | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sarray_spad_master.sv
// Strided load/store initiator between the systolic-array controller and spad.
// Optional stall counter port enabled by SARRAY_SPAD_MASTER_PERF_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready_o high
// LOAD  | issuing ar requests under FIFO credit, collecting r beats
// STORE | taking array beats into the aw holding register
// DONE  | one-cycle done_o pulse
module sarray_spad_master
  import sarray_spad_master_pkg::*;
#(
  parameter int ADDR_WIDTH  = SSM_ADDR_WIDTH,
  parameter int LOAD_WIDTH  = SSM_LOAD_WIDTH,
  parameter int STORE_WIDTH = SSM_STORE_WIDTH,
  parameter int LEN_WIDTH   = SSM_LEN_WIDTH,
  parameter int FIFO_DEPTH  = SSM_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]  cmd_base_i,
  input  logic [ADDR_WIDTH-1:0]  cmd_stride_i,
  input  logic [LEN_WIDTH-1:0]   cmd_len_i,
  output logic                   done_o,
  output logic                   ld_valid_o,
  input  logic                   ld_ready_i,
  output logic [LOAD_WIDTH-1:0]  ld_data_o,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [STORE_WIDTH-1:0] st_data_i,
  output logic                   sarray_ar_valid_o,
  input  logic                   sarray_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_ar_addr_o,
  input  logic                   sarray_r_valid_i,
  output logic                   sarray_r_ready_o,
  input  logic [LOAD_WIDTH-1:0]  sarray_r_data_i,
  output logic                   sarray_aw_valid_o,
  input  logic                   sarray_aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_aw_addr_o,
  output logic [STORE_WIDTH-1:0] sarray_aw_data_o
`ifdef SARRAY_SPAD_MASTER_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   issued_q, issued_d;
  logic [LEN_WIDTH-1:0]   accepted_q, accepted_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic                   aw_valid_q, aw_valid_d;
  logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_d;
  logic [STORE_WIDTH-1:0] aw_data_q, aw_data_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW:0]   credit_used;
  logic          ar_hs;
  logic          r_push;
  logic          st_hs;
  logic          aw_hs;
  logic          ld_pop;

  // spad ignores r_ready, so space is reserved for every outstanding read
  assign credit_used       = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign sarray_ar_valid_o = (state_q == ST_LOAD) && (issued_q < len_q) &&
                             (credit_used < (CW+1)'(FIFO_DEPTH));
  assign sarray_ar_addr_o  = addr_q;
  assign sarray_r_ready_o  = 1'b1;
  assign ar_hs             = sarray_ar_valid_o & sarray_ar_ready_i;
  assign r_push            = sarray_r_valid_i & (outstanding_q != '0);

  assign st_ready_o        = (state_q == ST_STORE) && (accepted_q < len_q) &&
                             (!aw_valid_q || sarray_aw_ready_i);
  assign st_hs             = st_valid_i & st_ready_o;
  assign aw_hs             = aw_valid_q & sarray_aw_ready_i;
  assign sarray_aw_valid_o = aw_valid_q;
  assign sarray_aw_addr_o  = aw_addr_q;
  assign sarray_aw_data_o  = aw_data_q;

  assign cmd_ready_o       = (state_q == ST_IDLE);
  assign done_o            = (state_q == ST_DONE);
  assign ld_valid_o        = ~fifo_empty;
  assign ld_pop            = ld_valid_o & ld_ready_i;

  sarray_ld_fifo #(
    .WIDTH (LOAD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ld_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (r_push),
    .push_data_i (sarray_r_data_i),
    .pop_i       (ld_pop),
    .pop_data_o  (ld_data_o),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    len_d         = len_q;
    issued_d      = issued_q;
    accepted_d    = accepted_q;
    outstanding_d = outstanding_q;
    aw_valid_d    = aw_valid_q;
    aw_addr_d     = aw_addr_q;
    aw_data_d     = aw_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d        = cmd_base_i;
          stride_d      = cmd_stride_i;
          len_d         = cmd_len_i;
          issued_d      = '0;
          accepted_d    = '0;
          outstanding_d = '0;
          if (cmd_len_i == '0)           state_d = ST_DONE;
          else if (cmd_op_i == OP_STORE) state_d = ST_STORE;
          else                           state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ar_hs) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        outstanding_d = outstanding_q + CW'(ar_hs) - CW'(r_push);
        if ((issued_d == len_q) && (outstanding_d == '0)) state_d = ST_DONE;
      end
      ST_STORE: begin
        if (st_hs) begin
          aw_valid_d = 1'b1;
          aw_addr_d  = addr_q;
          aw_data_d  = st_data_i;
          addr_d     = addr_q + stride_q;
          accepted_d = accepted_q + LEN_WIDTH'(1);
        end else if (aw_hs) begin
          aw_valid_d = 1'b0;
        end
        if ((accepted_d == len_q) && !aw_valid_d) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      outstanding_q <= '0;
      aw_valid_q    <= 1'b0;
      aw_addr_q     <= '0;
      aw_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      accepted_q    <= accepted_d;
      outstanding_q <= outstanding_d;
      aw_valid_q    <= aw_valid_d;
      aw_addr_q     <= aw_addr_d;
      aw_data_q     <= aw_data_d;
    end
  end

`ifdef SARRAY_SPAD_MASTER_PERF_EN
  logic [31:0] perf_q;
  logic        stall;

  assign stall            = (sarray_ar_valid_o & ~sarray_ar_ready_i) |
                            (aw_valid_q & ~sarray_aw_ready_i);
  assign perf_stall_cnt_o = perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      perf_q <= '0;
    else if (stall && (perf_q != '1)) perf_q <= perf_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sarray_spad_master.sv
// Self-checking bench for sarray_spad_master: command table plus credit-stall and mid-load reset sequences.
`timescale 1ns/1ps
module tb_sarray_spad_master;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int SW = 256;

  typedef struct {
    logic        op;
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] len;
    logic        aw_alt;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_op_i = 1'b0;
  logic [AW-1:0] cmd_base_i = '0;
  logic [AW-1:0] cmd_stride_i = '0;
  logic [15:0]   cmd_len_i = '0;
  logic          done_o;
  logic          ld_valid_o;
  logic          ld_ready_i = 1'b1;
  logic [LW-1:0] ld_data_o;
  logic          st_valid_i = 1'b0;
  logic          st_ready_o;
  logic [SW-1:0] st_data_i = '0;
  logic          sarray_ar_valid_o;
  logic          sarray_ar_ready_i = 1'b1;
  logic [AW-1:0] sarray_ar_addr_o;
  logic          sarray_r_valid_i = 1'b0;
  logic          sarray_r_ready_o;
  logic [LW-1:0] sarray_r_data_i = '0;
  logic          sarray_aw_valid_o;
  logic          sarray_aw_ready_i = 1'b1;
  logic [AW-1:0] sarray_aw_addr_o;
  logic [SW-1:0] sarray_aw_data_o;
`ifdef SARRAY_SPAD_MASTER_PERF_EN
  logic [31:0]   perf_stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]    exp_ar[$];
  logic [LW-1:0]    exp_ld[$];
  logic [AW+SW-1:0] exp_aw[$];
  logic [AW-1:0]    pend[$];

  int n_ar = 0, n_aw = 0, n_ld = 0, n_done = 0, n_r = 0, n_aw_stall = 0, cyc = 0;
  int cmd_cyc = 0, done_cyc = 0, last_ar_cyc = 0, last_aw_cyc = 0;
  logic [AW-1:0] last_ar_addr = '0, last_aw_addr = '0;
  logic aw_alt = 1'b0;
  int   r_limit = 1 << 30;

  logic          s_rst, s_cmd, s_ar, s_aw, s_ld, s_done;
  logic [AW-1:0] s_ar_addr, s_aw_addr;
  logic [SW-1:0] s_aw_data;
  logic [LW-1:0] s_ld_data;

  vec_t vecs[7];

  sarray_spad_master dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_op_i          (cmd_op_i),
    .cmd_base_i        (cmd_base_i),
    .cmd_stride_i      (cmd_stride_i),
    .cmd_len_i         (cmd_len_i),
    .done_o            (done_o),
    .ld_valid_o        (ld_valid_o),
    .ld_ready_i        (ld_ready_i),
    .ld_data_o         (ld_data_o),
    .st_valid_i        (st_valid_i),
    .st_ready_o        (st_ready_o),
    .st_data_i         (st_data_i),
    .sarray_ar_valid_o (sarray_ar_valid_o),
    .sarray_ar_ready_i (sarray_ar_ready_i),
    .sarray_ar_addr_o  (sarray_ar_addr_o),
    .sarray_r_valid_i  (sarray_r_valid_i),
    .sarray_r_ready_o  (sarray_r_ready_o),
    .sarray_r_data_i   (sarray_r_data_i),
    .sarray_aw_valid_o (sarray_aw_valid_o),
    .sarray_aw_ready_i (sarray_aw_ready_i),
    .sarray_aw_addr_o  (sarray_aw_addr_o),
    .sarray_aw_data_o  (sarray_aw_data_o)
`ifdef SARRAY_SPAD_MASTER_PERF_EN
    ,
    .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rdata(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_5A5A}};
  endfunction

  function automatic logic [SW-1:0] sdata(input int row, input int b);
    return {8{32'hC0DE_0000 + 32'(row * 256 + b)}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected required=event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // spad model + monitor: samples handshakes before each edge, returns r one cycle after ar
  always begin
    @(negedge clk);
    s_rst     = rst_n;
    s_cmd     = cmd_valid_i & cmd_ready_o;
    s_ar      = sarray_ar_valid_o & sarray_ar_ready_i;
    s_ar_addr = sarray_ar_addr_o;
    s_aw      = sarray_aw_valid_o & sarray_aw_ready_i;
    s_aw_addr = sarray_aw_addr_o;
    s_aw_data = sarray_aw_data_o;
    s_ld      = ld_valid_o & ld_ready_i;
    s_ld_data = ld_data_o;
    s_done    = done_o;
    if (rst_n && sarray_aw_valid_o && !sarray_aw_ready_i) begin
      n_aw_stall++;
      chk("st_ready_while_aw_held", 256'(st_ready_o), 256'(0));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      if (s_cmd) cmd_cyc = cyc;
      if (s_ar) begin
        n_ar++;
        last_ar_cyc  = cyc;
        last_ar_addr = s_ar_addr;
        pend.push_back(s_ar_addr);
        if (exp_ar.size() == 0) fail("ar_unexpected");
        else chk("ar_addr", 256'(s_ar_addr), 256'(exp_ar.pop_front()));
      end
      if (s_aw) begin
        n_aw++;
        last_aw_cyc  = cyc;
        last_aw_addr = s_aw_addr;
        if (exp_aw.size() == 0) fail("aw_unexpected");
        else chk("aw_addr_data", 256'({s_aw_addr, s_aw_data} ^ exp_aw.pop_front()), 256'(0));
      end
      if (s_ld) begin
        n_ld++;
        if (exp_ld.size() == 0) fail("ld_unexpected");
        else chk("ld_data", s_ld_data, exp_ld.pop_front());
      end
      if (s_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    if (!rst_n) pend.delete();
    if (rst_n && pend.size() > 0 && n_r < r_limit) begin
      sarray_r_valid_i = 1'b1;
      sarray_r_data_i  = rdata(pend.pop_front());
      n_r++;
    end else begin
      sarray_r_valid_i = 1'b0;
      sarray_r_data_i  = '0;
    end
    sarray_aw_ready_i = aw_alt ? ~sarray_aw_ready_i : 1'b1;
  end

  task automatic send_cmd(input logic op, input logic [31:0] base, input logic [31:0] stride,
                          input logic [15:0] len);
    logic hs;
    logic ok;
    ok = 1'b0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_base_i = base; cmd_stride_i = stride; cmd_len_i = len;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      hs = cmd_ready_o;
      step();
      if (hs) begin ok = 1'b1; break; end
    end
    cmd_valid_i = 1'b0;
    if (!ok) fail("cmd_handshake");
  endtask

  task automatic st_send(input logic [SW-1:0] d);
    logic hs;
    logic ok;
    ok = 1'b0;
    st_valid_i = 1'b1;
    st_data_i  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      hs = st_ready_o;
      step();
      if (hs) begin ok = 1'b1; break; end
    end
    st_valid_i = 1'b0;
    if (!ok) fail("st_handshake");
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 300 && n_done <= d0; k++) step();
    if (n_done <= d0) fail("done_timeout");
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 300 && (exp_ar.size() + exp_ld.size() + exp_aw.size()) != 0; k++) step();
    if ((exp_ar.size() + exp_ld.size() + exp_aw.size()) != 0) fail("scoreboard_drain");
  endtask

  task automatic push_load(input logic [31:0] base, input logic [31:0] stride, input int len);
    logic [31:0] a;
    for (int b = 0; b < len; b++) begin
      a = base + stride * 32'(b);
      exp_ar.push_back(a);
      exp_ld.push_back(rdata(a));
    end
  endtask

  task automatic run_row(input int i);
    vec_t v;
    logic [31:0] a;
    int d0, ar0, aw0, ld0, stall0;
    v = vecs[i];
    if (v.op == 1'b0) push_load(v.base, v.stride, int'(v.len));
    else begin
      for (int b = 0; b < int'(v.len); b++) begin
        a = v.base + v.stride * 32'(b);
        exp_aw.push_back({a, sdata(i, b)});
      end
    end
    aw_alt = v.aw_alt;
    d0 = n_done; ar0 = n_ar; aw0 = n_aw; ld0 = n_ld; stall0 = n_aw_stall;
    send_cmd(v.op, v.base, v.stride, v.len);
    if (v.op == 1'b1)
      for (int b = 0; b < int'(v.len); b++) st_send(sdata(i, b));
    wait_done(d0);
    wait_empty();
    repeat (4) step();
    chk($sformatf("row%0d_done_once", i), 256'(n_done - d0), 256'(1));
    chk($sformatf("row%0d_ar_count", i), 256'(n_ar - ar0), 256'(v.op ? 0 : v.exp_beats));
    chk($sformatf("row%0d_ld_count", i), 256'(n_ld - ld0), 256'(v.op ? 0 : v.exp_beats));
    chk($sformatf("row%0d_aw_count", i), 256'(n_aw - aw0), 256'(v.op ? v.exp_beats : 0));
    if (v.len == 0)
      chk($sformatf("row%0d_done_lat_cmd", i), 256'(done_cyc - cmd_cyc), 256'(1));
    else if (v.op == 1'b0)
      chk($sformatf("row%0d_done_lat_ar", i), 256'(done_cyc - last_ar_cyc), 256'(2));
    else
      chk($sformatf("row%0d_done_lat_aw", i), 256'(done_cyc - last_aw_cyc), 256'(1));
    if (v.exp_beats > 0)
      chk($sformatf("row%0d_last_addr", i), 256'(v.op ? last_aw_addr : last_ar_addr), 256'(v.exp_last));
    if (v.aw_alt)
      chk($sformatf("row%0d_aw_stall_seen", i), 256'(n_aw_stall > stall0), 256'(1));
    aw_alt = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ar0, ld0;
    vecs[0] = '{1'b0, 32'h10,       32'd1,        16'd6, 1'b0, 6, 32'h15};
    vecs[1] = '{1'b0, 32'hFFFFFFFE, 32'd1,        16'd4, 1'b0, 4, 32'h1};
    vecs[2] = '{1'b1, 32'h100,      32'd4,        16'd3, 1'b1, 3, 32'h108};
    vecs[3] = '{1'b0, 32'h0,        32'd1,        16'd0, 1'b0, 0, 32'h0};
    vecs[4] = '{1'b1, 32'h50,       32'd4,        16'd0, 1'b0, 0, 32'h0};
    vecs[5] = '{1'b0, 32'h1000,     32'h20,       16'd5, 1'b0, 5, 32'h1080};
    vecs[6] = '{1'b1, 32'h40,       32'hFFFFFFFC, 16'd4, 1'b0, 4, 32'h34};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd_ready", 256'(cmd_ready_o), 256'(1));
    chk("rst_r_ready", 256'(sarray_r_ready_o), 256'(1));
    chk("rst_valids", 256'({sarray_ar_valid_o, sarray_aw_valid_o, ld_valid_o, st_ready_o, done_o}), 256'(0));
    chk("rst_ar_addr", 256'(sarray_ar_addr_o), 256'(0));
    chk("rst_aw_addr", 256'(sarray_aw_addr_o), 256'(0));
    chk("rst_aw_data", sarray_aw_data_o, 256'(0));
    chk("rst_ld_data", ld_data_o, 256'(0));
`ifdef SARRAY_SPAD_MASTER_PERF_EN
    chk("rst_perf", 256'(perf_stall_cnt_o), 256'(0));
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_row(i);

    // credit stall: ld_ready held low, only FIFO_DEPTH reads may be in flight
    push_load(32'h400, 32'd1, 8);
    ld_ready_i = 1'b0;
    d0 = n_done; ar0 = n_ar; ld0 = n_ld;
    send_cmd(1'b0, 32'h400, 32'd1, 16'd8);
    repeat (18) step();
    @(negedge clk);
    chk("credit_ar_valid", 256'(sarray_ar_valid_o), 256'(0));
    chk("credit_ar_count", 256'(n_ar - ar0), 256'(4));
    chk("credit_ld_valid", 256'(ld_valid_o), 256'(1));
    step();
    ld_ready_i = 1'b1;
    wait_done(d0);
    wait_empty();
    repeat (4) step();
    chk("credit_total_ar", 256'(n_ar - ar0), 256'(8));
    chk("credit_total_ld", 256'(n_ld - ld0), 256'(8));
    chk("credit_done_once", 256'(n_done - d0), 256'(1));

    // reset with two entries in the FIFO and two reads outstanding
    push_load(32'h200, 32'd1, 6);
    ld_ready_i = 1'b0;
    r_limit = n_r + 2;
    d0 = n_done; ar0 = n_ar;
    send_cmd(1'b0, 32'h200, 32'd1, 16'd6);
    repeat (12) step();
    @(negedge clk);
    chk("prerst_ar_stall", 256'(sarray_ar_valid_o), 256'(0));
    chk("prerst_ar_count", 256'(n_ar - ar0), 256'(4));
    chk("prerst_ld_valid", 256'(ld_valid_o), 256'(1));
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", 256'({sarray_ar_valid_o, sarray_aw_valid_o, ld_valid_o, done_o}), 256'(0));
    chk("midrst_cmd_ready", 256'(cmd_ready_o), 256'(1));
    chk("midrst_ld_data", ld_data_o, 256'(0));
    exp_ar.delete();
    exp_ld.delete();
    r_limit = 1 << 30;
    repeat (2) step();
    rst_n = 1'b1;
    ld_ready_i = 1'b1;
    repeat (3) step();
    chk("midrst_no_done", 256'(n_done - d0), 256'(0));
    chk("midrst_fifo_empty", 256'(ld_valid_o), 256'(0));
`ifdef SARRAY_SPAD_MASTER_PERF_EN
    chk("midrst_perf", 256'(perf_stall_cnt_o), 256'(0));
`endif
    run_row(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
